// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ADD/AND/NOT/PASS, iterative shift-add MUL and 1-bit/cycle shifts.
// Result and NZP are registered; Done/Busy are decoded from the FSM state.
module alu_exec_unit #(
    parameter int N = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [2:0]   ALUK,
    input  logic         SR2MUX,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B_Reg,
    input  logic [4:0]   Imm5,
    output logic [N-1:0] Result,
    output logic         Done,
    output logic         Busy,
    output logic [2:0]   NZP
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [4:0]   count_q, count_d;
    logic [N-1:0] work_q, work_d;     // shift operand, or MUL multiplicand
    logic [N-1:0] opb_q, opb_d;       // MUL multiplier, consumed LSB first
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] result_q, result_d;
    logic [2:0]   nzp_q, nzp_d;

    logic [N-1:0] b_sel;
    logic [N-1:0] acc_next;
    logic [N-1:0] work_next;
    logic         accept;

    function automatic logic [2:0] cc(input logic [N-1:0] r);
        if (r[N-1])
            return 3'b100;
        else if (r == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    assign b_sel  = SR2MUX ? {{(N-5){Imm5[4]}}, Imm5} : B_Reg;
    assign accept = Start && (state_q != CALC);

    // Low N bits of a two's-complement product equal the unsigned product's.
    assign acc_next = acc_q + (opb_q[0] ? work_q : '0);

    always_comb begin
        work_next = work_q;
        case (op_q)
            OP_MUL:  work_next = work_q << 1;
            OP_SHL:  work_next = work_q << 1;
            OP_SRA:  work_next = {work_q[N-1], work_q[N-1:1]};
            default: work_next = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        work_d   = work_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        nzp_d    = nzp_q;

        if (accept) begin
            op_d = ALUK;
            case (ALUK)
                OP_MUL: begin
                    work_d  = A;
                    opb_d   = b_sel;
                    acc_d   = '0;
                    count_d = 5'd16;
                    state_d = CALC;
                end
                OP_SHL, OP_SRA: begin
                    if (b_sel[3:0] == 4'd0) begin
                        result_d = A;
                        nzp_d    = cc(A);
                        state_d  = DONE;
                    end else begin
                        work_d  = A;
                        count_d = {1'b0, b_sel[3:0]};
                        state_d = CALC;
                    end
                end
                default: begin
                    case (ALUK)
                        OP_ADD:  result_d = A + b_sel;
                        OP_AND:  result_d = A & b_sel;
                        OP_NOT:  result_d = ~A;
                        default: result_d = A;
                    endcase
                    nzp_d   = cc(result_d);
                    state_d = DONE;
                end
            endcase
        end else if (state_q == CALC) begin
            count_d = count_q - 5'd1;
            work_d  = work_next;
            if (op_q == OP_MUL) begin
                acc_d = acc_next;
                opb_d = opb_q >> 1;
            end
            if (count_q == 5'd1) begin
                result_d = (op_q == OP_MUL) ? acc_next : work_next;
                nzp_d    = cc(result_d);
                state_d  = DONE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            count_q  <= '0;
            work_q   <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            nzp_q    <= 3'b010;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            work_q   <= work_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
        end
    end

    assign Result = result_q;
    assign NZP    = nzp_q;
    assign Done   = (state_q == DONE);
    assign Busy   = (state_q == CALC);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values hand-computed.
module tb_alu_exec_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  ALUK = 3'd0;
    logic        SR2MUX = 1'b0;
    logic [15:0] A = 16'd0;
    logic [15:0] B_Reg = 16'd0;
    logic [4:0]  Imm5 = 5'd0;
    logic [15:0] Result;
    logic        Done;
    logic        Busy;
    logic [2:0]  NZP;

    int checks = 0;
    int failures = 0;

    alu_exec_unit #(.N(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ALUK(ALUK), .SR2MUX(SR2MUX),
        .A(A), .B_Reg(B_Reg), .Imm5(Imm5),
        .Result(Result), .Done(Done), .Busy(Busy), .NZP(NZP)
    );

    always #5 Clk = ~Clk;

    // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Pulse Start for one cycle, then wait (bounded) for Done.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic sr2, input logic [4:0] imm,
                          output int lat, output int busy_cnt);
        ALUK = op; A = a; B_Reg = b; SR2MUX = sr2; Imm5 = imm;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!Done && lat < 40) begin
            if (Busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        tick(); tick(); tick();
        checks++; if (Result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", Result); end
        checks++; if (NZP !== 3'b010) begin failures++; $display("FAIL reset_nzp got=%b exp=010", NZP); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(3'b000, 16'h7FFF, 16'h0001, 1'b0, 5'd0, lat, bc);
        checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (Result !== 16'h8000) begin failures++; $display("FAIL add_result got=%h exp=8000", Result); end
        checks++; if (NZP !== 3'b100) begin failures++; $display("FAIL add_nzp got=%b exp=100", NZP); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", Done); end
        checks++; if (Result !== 16'h8000) begin failures++; $display("FAIL add_hold got=%h exp=8000", Result); end
        run_op(3'b000, 16'h0001, 16'h1234, 1'b1, 5'b11111, lat, bc);
        checks++; if (lat !== 1) begin failures++; $display("FAIL addimm_latency got=%0d exp=1", lat); end
        checks++; if (Result !== 16'h0000) begin failures++; $display("FAIL addimm_result got=%h exp=0000", Result); end
        checks++; if (NZP !== 3'b010) begin failures++; $display("FAIL addimm_nzp got=%b exp=010", NZP); end
        tick();
    endtask

    task automatic test_mul();
        int busy_ok;
        busy_ok = 1;
        ALUK = 3'b100; A = 16'hFFFD; B_Reg = 16'h0007; SR2MUX = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        // Now in cycle t+1; expect Busy through t+16.
        for (int i = 1; i <= 16; i++) begin
            if (Busy !== 1'b1 || Done !== 1'b0) busy_ok = 0;
            if (i == 4) begin
                Start = 1'b1; ALUK = 3'b000; A = 16'h1111; B_Reg = 16'h2222;
            end
            if (i == 5) Start = 1'b0;
            tick();
        end
        checks++; if (busy_ok !== 1) begin failures++; $display("FAIL mul_busy_window got=%0d exp=1", busy_ok); end
        checks++; if (Done !== 1'b1) begin failures++; $display("FAIL mul_done_t17 got=%b exp=1", Done); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mul_busy_end got=%b exp=0", Busy); end
        checks++; if (Result !== 16'hFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffeb", Result); end
        checks++; if (NZP !== 3'b100) begin failures++; $display("FAIL mul_nzp got=%b exp=100", NZP); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL mul_start_ignored got=%b exp=0", Done); end
    endtask

    task automatic test_shift();
        int lat, bc;
        run_op(3'b110, 16'h8000, 16'h0004, 1'b0, 5'd0, lat, bc);
        checks++; if (lat !== 5) begin failures++; $display("FAIL sra_latency got=%0d exp=5", lat); end
        checks++; if (bc !== 4) begin failures++; $display("FAIL sra_busy got=%0d exp=4", bc); end
        checks++; if (Result !== 16'hF800) begin failures++; $display("FAIL sra_result got=%h exp=f800", Result); end
        tick();
        run_op(3'b101, 16'h0001, 16'h000F, 1'b0, 5'd0, lat, bc);
        checks++; if (lat !== 16) begin failures++; $display("FAIL shl15_latency got=%0d exp=16", lat); end
        checks++; if (Result !== 16'h8000) begin failures++; $display("FAIL shl15_result got=%h exp=8000", Result); end
        checks++; if (NZP !== 3'b100) begin failures++; $display("FAIL shl15_nzp got=%b exp=100", NZP); end
        tick();
        run_op(3'b101, 16'h1234, 16'h0010, 1'b0, 5'd0, lat, bc);
        checks++; if (lat !== 1) begin failures++; $display("FAIL shl0_latency got=%0d exp=1", lat); end
        checks++; if (bc !== 0) begin failures++; $display("FAIL shl0_busy got=%0d exp=0", bc); end
        checks++; if (Result !== 16'h1234) begin failures++; $display("FAIL shl0_result got=%h exp=1234", Result); end
        checks++; if (NZP !== 3'b001) begin failures++; $display("FAIL shl0_nzp got=%b exp=001", NZP); end
        tick();
        run_op(3'b111, 16'h00A5, 16'h0000, 1'b0, 5'd0, lat, bc);
        checks++; if (Result !== 16'h00A5) begin failures++; $display("FAIL rsvd_pass got=%h exp=00a5", Result); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(3'b010, 16'h0000, 16'h0000, 1'b0, 5'd0, lat, bc);
        checks++; if (Result !== 16'hFFFF) begin failures++; $display("FAIL not_result got=%h exp=ffff", Result); end
        ALUK = 3'b001; A = 16'h00FF; B_Reg = 16'h0F0F; SR2MUX = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++; if (Done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", Done); end
        checks++; if (Result !== 16'h000F) begin failures++; $display("FAIL b2b_result got=%h exp=000f", Result); end
        checks++; if (NZP !== 3'b001) begin failures++; $display("FAIL b2b_nzp got=%b exp=001", NZP); end
        tick();
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b exp=0", Done); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, bc, done_seen;
        ALUK = 3'b100; A = 16'h0003; B_Reg = 16'h0005; SR2MUX = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", Busy); end
        checks++; if (Result !== 16'h0000) begin failures++; $display("FAIL rst_mid_result got=%h exp=0000", Result); end
        checks++; if (NZP !== 3'b010) begin failures++; $display("FAIL rst_mid_nzp got=%b exp=010", NZP); end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done === 1'b1) done_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_seen); end
        run_op(3'b000, 16'h0003, 16'h0004, 1'b0, 5'd0, lat, bc);
        checks++; if (lat !== 1) begin failures++; $display("FAIL post_rst_latency got=%0d exp=1", lat); end
        checks++; if (Result !== 16'h0007) begin failures++; $display("FAIL post_rst_result got=%h exp=0007", Result); end
        checks++; if (NZP !== 3'b001) begin failures++; $display("FAIL post_rst_nzp got=%b exp=001", NZP); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_shift();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute stage directly downstream of the 8x16 general-purpose register file: consumes the SR1/SR2 read ports, selects the second operand (register or sign-extended imm5), and computes ADD/AND/NOT/PASS in one cycle, or MUL and shifts iteratively. It holds the result in an output register for the writeback bus and updates the NZP condition-code register. The control FSM drives it with a Start/Done handshake.

## Interface

- Parameters
  - N, 16, datapath width; only 16 is supported.
- Ports
  - Clk  in  1  system clock, all state updates on rising edge.
  - Reset  in  1  synchronous, active-high.
  - Start  in  1  request to begin an operation; sampled on rising edge.
  - ALUK  in  3  operation select, sampled with Start.
  - SR2MUX  in  1  1 = B is sign-extended Imm5; 0 = B is B_Reg.
  - A  in  N  operand A (register file SR1 output).
  - B_Reg  in  N  operand B from the register file SR2 output.
  - Imm5  in  5  immediate field IR[4:0].
  - Result  out  N  registered result.
  - Done  out  1  one-cycle pulse: Result and NZP are valid and updated.
  - Busy  out  1  high while an iterative operation is in progress.
  - NZP  out  3  condition codes {N,Z,P}, always one-hot.

## Operation

- B = SR2MUX ? {{11{Imm5[4]}}, Imm5} : B_Reg. A, B and ALUK are latched only when Start is accepted; later input changes have no effect on the operation in flight.
- ALUK encoding:
  - 000 ADD: A+B mod 2^16.
  - 001 AND: A&B.
  - 010 NOT: ~A.
  - 011 PASS: A.
  - 100 MUL: low 16 bits of A*B, shift-add, 16 iterations. The result is correct for both signed and unsigned operands.
  - 101 SHL: A << B[3:0], 1 bit per iteration.
  - 110 SRA: A >>> B[3:0], arithmetic, 1 bit per iteration.
  - 111 reserved: behaves as PASS.
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE + Start, ops 000-011, 111 → DONE. Result is written on the same edge.
  - IDLE/DONE + Start, MUL → CALC with count 16.
  - IDLE/DONE + Start, shift with B[3:0]=0 → DONE. Result = A.
  - IDLE/DONE + Start, shift with B[3:0]=c>0 → CALC with count c.
  - CALC: one iteration per edge and count is decremented. The edge on which count goes 1→0 writes Result and moves to DONE.
  - DONE without Start → IDLE.
- Start while in CALC is ignored: no queueing, no abort.
- Start is accepted in DONE, so operations can run back-to-back.
- Busy = (state==CALC). Done = (state==DONE).
- Result changes only on entry to DONE; it holds its value otherwise, including through IDLE.
- NZP is updated on the same edge as Result:
  - N=Result[15].
  - Z=(Result==0).
  - P=otherwise.
- Reset (any state, including mid-CALC): state IDLE, Result=0, Done=0, Busy=0, NZP=3'b010. An aborted operation never produces Done.

## Timing

- If Start is accepted in cycle t, Done is high in cycle:
  - t+1 for single-cycle ops, and for shifts by 0.
  - t+17 for MUL.
  - t+1+c for shifts by c.
- Busy is high in cycles t+1 through t+16 for MUL, and t+1 through t+c for shifts.
- Result and NZP are stable from the cycle Done rises until the next Done.
- Done is never high for two consecutive cycles unless Start is re-asserted during DONE.
- No combinational path from inputs to any output; all outputs are registered or decoded from state.
- Reset takes priority over Start on the same edge.

## Test plan

- Reset, then idle 3 cycles:
  - Result=0, NZP=010, Done=0, Busy=0.
- ADD A=0x7FFF, B_Reg=0x0001, SR2MUX=0, Start 1 cycle:
  - Done in the next cycle, Result=0x8000, NZP=100.
  - Then ADD with SR2MUX=1, Imm5=5'b11111, A=0x0001: Result=0x0000, NZP=010.
- MUL A=0xFFFD (-3), B=0x0007:
  - Busy for 16 cycles, Done at t+17, Result=0xFFEB, NZP=100.
  - Pulse Start with ALUK=000 at t+5: ignored, result unchanged.
- SRA A=0x8000, B_Reg=0x0004:
  - Done at t+5, Result=0xF800.
  - SHL A=0x0001 by 15 → 0x8000 at t+16.
  - SHL by 0 → Done at t+1, Result=A.
- Back-to-back: NOT A=0x0000 → Result 0xFFFF, then Start AND 0x00FF & 0x0F0F while Done is high:
  - Second Done in the next cycle, Result=0x000F, NZP=001.
- Reset asserted during MUL iteration 8:
  - No Done, Result=0, NZP=010.
  - A new ADD started 1 cycle later completes normally.
